des_key_sched_dec: RTL
======================

Name: des_key_sched_dec

Overview:
- Sequential DES key scheduler that produces the 16 48-bit round subkeys for the decrypt data path, in reverse order K16, K15, ..., K1.
- Also supports forward order K1..K16 for the encrypt path, selected per key.
- Sits between the key input interface and the round/S-box pipeline.
- Delivers one subkey per valid/ready handshake, so the round logic can stall it.

Parameters:
- KEY_WIDTH, 64, input key width including the 8 parity bits; fixed at 64.
- SUBKEY_WIDTH, 48, round subkey width; fixed at 48.
- HALF_WIDTH, 28, width of each C/D key half; fixed at 28.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  64  DES key. key_in[63] is DES bit 1, key_in[0] is DES bit 64. Parity bits 8,16,...,64 are ignored.
- decrypt  input  1  sampled with key_in. 1 = emit K16..K1; 0 = emit K1..K16.
- key_valid  input  1  key_in and decrypt are valid.
- key_ready  output  1  block can accept a new key.
- subkey  output  48  current round subkey; subkey[47] is PC-2 output bit 1.
- round_idx  output  4  DES round number minus 1 of the subkey presented (K16 -> 15).
- subkey_valid  output  1  subkey and round_idx are valid.
- subkey_ready  input  1  consumer accepts subkey this cycle.
- done  output  1  one-cycle pulse after the final subkey handshake.

Behaviour:
- Tables: PC-1, PC-2 and the left-shift schedule are per FIPS 46-3.
  - Shift schedule: rounds 1, 2, 9, 16 shift by 1; all other rounds shift by 2.
- State: registers C[27:0], D[27:0], rnd[3:0], dir, plus FSM state {IDLE, RUN}.
- Reset (rst high at a clock edge):
  - state = IDLE; C = D = 0; rnd = 0; subkey_valid = 0; done = 0.
  - round_idx reads 0, subkey reads PC-2(0,0) = 0.
  - Reset mid-sequence abandons the sequence with no done pulse.
- key_ready = (state == IDLE) & ~rst, combinational.
- Key accept: key_valid & key_ready at edge N.
  - {C,D} = PC-1(key_in). If decrypt = 0, both halves are additionally rotated left by 1, giving C1/D1.
  - dir = decrypt. rnd = 15 if decrypt, else 0. state = RUN.
  - subkey_valid is first high in cycle N+1 (1-cycle latency).
- RUN:
  - subkey_valid = 1; subkey = PC-2(C,D), combinational from registers; round_idx = rnd.
  - Outputs hold stable while subkey_ready = 0; unlimited stall allowed.
- Handshake (subkey_valid & subkey_ready), not the final one:
  - dir = 1: rotate C and D right by shift[rnd+1], i.e. the shift of the round just emitted; rnd decrements.
  - dir = 0: rotate C and D left by shift[rnd+2], i.e. the shift of the next round; rnd increments.
- Final handshake (dir=1 & rnd=0, or dir=0 & rnd=15):
  - state = IDLE; subkey_valid = 0 next cycle; done = 1 for exactly that next cycle.
  - No rotation is required on the final handshake. C/D contents after done are don't-care.
- Rotation totals:
  - Decrypt: K16 uses the unrotated C0/D0; cumulative right rotation before K1 is 27.
  - Encrypt: cumulative left rotation at K16 is 28, which equals C0/D0.
- Throughput and turnaround:
  - One subkey per cycle with subkey_ready held high.
  - A full sequence takes 16 cycles after the accept cycle.
  - key_ready returns in the done cycle, so back-to-back keys have one idle cycle between sequences.
- key_valid while key_ready = 0 is ignored; the source must hold it until accepted.
- Inputs key_in and decrypt are not used outside the accept edge.

Test Plan:
- Decrypt order: rst for 2 cycles, then key 133457799BBCDFF1 with decrypt = 1, subkey_ready = 1.
  - Required: cycle N+1 subkey CB3D8B0E17F5, round_idx 15; N+2 BF918D3D3F0A, idx 14; N+15 79AED9DBC9E5, idx 1; N+16 1B02EFFC7072, idx 0; done in N+17.
- Encrypt order: same key with decrypt = 0.
  - Required: 1B02EFFC7072 (idx 0), 79AED9DBC9E5 (idx 1), ..., BF918D3D3F0A (idx 14), CB3D8B0E17F5 (idx 15).
  - Across every round, the sequence equals the decrypt sequence reversed.
- Backpressure: decrypt run with subkey_ready pseudo-random (about 50%).
  - Required: the same 16 subkeys in order, none skipped or repeated; subkey/round_idx stable during stalls; exactly one done pulse.
- Parity independence: key 133457799BBCDFF1 vs 123456789ABCDEF0 differ in parity bits only? No — instead use key 0000000000000000 vs 0101010101010101.
  - Required: identical subkeys, all 000000000000.
- Reset mid-run: assert rst after the 5th handshake.
  - Required: next cycle subkey_valid = 0, no done, key_ready = 1 after rst falls; a new key then yields the correct full sequence.
- Key source stress: key_valid held high during RUN.
  - Required: no accept until done; next key accepted in the done cycle.
  - Required: key_valid while rst = 1 is never accepted.

Source files
------------

// File: rtl/des_key_sched_dec.sv
// DES round-subkey scheduler: emits K16..K1 (decrypt) or K1..K16 (encrypt),
// one subkey per valid/ready handshake.
module des_key_sched_dec #(
   parameter int KEY_WIDTH    = 64,
   parameter int SUBKEY_WIDTH = 48,
   parameter int HALF_WIDTH   = 28
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [KEY_WIDTH-1:0]    key_in,
   input  logic                    decrypt,
   input  logic                    key_valid,
   output logic                    key_ready,
   output logic [SUBKEY_WIDTH-1:0] subkey,
   output logic [3:0]              round_idx,
   output logic                    subkey_valid,
   input  logic                    subkey_ready,
   output logic                    done
);

   localparam int unsigned PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state, state_nxt;
   logic [HALF_WIDTH-1:0]   c_q, d_q, c_nxt, d_nxt;
   logic [3:0]              rnd_q, rnd_nxt;
   logic                    dir_q, dir_nxt;
   logic                    done_q, done_nxt;
   logic [2*HALF_WIDTH-1:0] cd_key;
   logic                    last_round;

   // DES bit n of the key lives at key_in[64-n]; bit 1 of the result is the MSB.
   function automatic logic [2*HALF_WIDTH-1:0] pc1(input logic [KEY_WIDTH-1:0] k);
      logic [2*HALF_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < 56; i++)
         r[55-i] = k[64-PC1_TAB[i]];
      return r;
   endfunction

   function automatic logic [SUBKEY_WIDTH-1:0] pc2(input logic [2*HALF_WIDTH-1:0] cd);
      logic [SUBKEY_WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < 48; i++)
         r[47-i] = cd[56-PC2_TAB[i]];
      return r;
   endfunction

   // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
   function automatic logic shift_two(input logic [4:0] round);
      return !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
   endfunction

   function automatic logic [HALF_WIDTH-1:0] rotl(input logic [HALF_WIDTH-1:0] x,
                                                  input logic two);
      return two ? {x[HALF_WIDTH-3:0], x[HALF_WIDTH-1:HALF_WIDTH-2]}
                 : {x[HALF_WIDTH-2:0], x[HALF_WIDTH-1]};
   endfunction

   function automatic logic [HALF_WIDTH-1:0] rotr(input logic [HALF_WIDTH-1:0] x,
                                                  input logic two);
      return two ? {x[1:0], x[HALF_WIDTH-1:2]}
                 : {x[0], x[HALF_WIDTH-1:1]};
   endfunction

   assign key_ready    = (state == IDLE) & ~rst;
   assign subkey_valid = (state == RUN);
   assign subkey       = pc2({c_q, d_q});
   assign round_idx    = rnd_q;
   assign done         = done_q;
   assign cd_key       = pc1(key_in);
   assign last_round   = dir_q ? (rnd_q == 4'd0) : (rnd_q == 4'd15);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         c_q    <= '0;
         d_q    <= '0;
         rnd_q  <= '0;
         dir_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         c_q    <= c_nxt;
         d_q    <= d_nxt;
         rnd_q  <= rnd_nxt;
         dir_q  <= dir_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      c_nxt     = c_q;
      d_nxt     = d_q;
      rnd_nxt   = rnd_q;
      dir_nxt   = dir_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (key_valid && key_ready) begin
               // Decrypt starts from C0/D0, which already equals C16/D16.
               c_nxt     = decrypt ? cd_key[55:28] : rotl(cd_key[55:28], 1'b0);
               d_nxt     = decrypt ? cd_key[27:0]  : rotl(cd_key[27:0], 1'b0);
               dir_nxt   = decrypt;
               rnd_nxt   = decrypt ? 4'd15 : 4'd0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (subkey_ready) begin
               if (last_round) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else if (dir_q) begin
                  c_nxt   = rotr(c_q, shift_two({1'b0, rnd_q} + 5'd1));
                  d_nxt   = rotr(d_q, shift_two({1'b0, rnd_q} + 5'd1));
                  rnd_nxt = rnd_q - 4'd1;
               end else begin
                  c_nxt   = rotl(c_q, shift_two({1'b0, rnd_q} + 5'd2));
                  d_nxt   = rotl(d_q, shift_two({1'b0, rnd_q} + 5'd2));
                  rnd_nxt = rnd_q + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
